instr_fetch_stage: RTL and testbench
====================================

# instr_fetch_stage

Instruction fetch (IF) stage of the five-stage ARM pipeline. Holds the program counter, drives the word address of an asynchronous-read instruction memory, and presents the fetched instruction and `PC+4` to the IF/ID pipeline register in the same cycle. It also handles freeze (hazard stall), taken-branch redirect, out-of-range fetch protection and three performance counters.

## Interface
- `INIT_PC`, 32'h0000_0000: PC value loaded on reset.
- `MEM_DEPTH`, 64: instruction memory depth in 32-bit words. Valid fetch word indices are 0..MEM_DEPTH-1.
- `NOP_INSTR`, 32'hE1A0_0000: instruction substituted on an out-of-range fetch (MOV R0,R0).

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `freeze`, input, 1: hazard stall from the hazard unit; holds the PC.
- `branch_taken`, input, 1: redirect request from EXE.
- `branch_addr`, input, 32: branch target byte address.
- `imem_addr`, output, 32: byte address to the instruction memory; equals the PC.
- `imem_rdata`, input, 32: memory read data, combinational from `imem_addr`.
- `pc_out`, output, 32: PC+4, to IF/ID.
- `instruction_out`, output, 32: fetched instruction, to IF/ID.
- `fetch_fault`, output, 1: sticky; set by an out-of-range fetch.
- `misalign_fault`, output, 1: sticky; set by a branch target with `[1:0]≠0`.
- `fetch_count`, output, 32: number of PC advances (sequential or branch), wrapping.
- `stall_count`, output, 16: number of freeze cycles, saturating at 16'hFFFF.
- `branch_count`, output, 16: number of taken branches, wrapping.

## Operation
- PC register update priority, evaluated at each rising edge: reset > `branch_taken` > `freeze` > sequential.
  - Reset (`rst`=0): PC←INIT_PC. Both faults←0. All counters←0.
  - `branch_taken`=1: PC←{branch_addr[31:2],2'b00}. `fetch_count`+1, `branch_count`+1. If `branch_addr[1:0]≠0`, set `misalign_fault`. A branch overrides a simultaneous freeze; `stall_count` does not increment in that cycle.
  - `freeze`=1 without a branch: PC holds. `stall_count`+1 unless already 16'hFFFF.
  - Otherwise: PC←PC+4, with 32-bit wrap (32'hFFFF_FFFC→0). `fetch_count`+1.
- Combinational outputs:
  - `imem_addr`=PC.
  - `pc_out`=PC+4 (mod 2^32).
  - `instruction_out`=`imem_rdata` when PC[31:2] < MEM_DEPTH, else NOP_INSTR.
- Out-of-range fetch:
  - `fetch_fault` is set at the next edge whenever PC[31:2] ≥ MEM_DEPTH. This applies even while frozen.
  - `fetch_fault` is cleared only by reset.
- Flushing the fetched instruction on a branch is the IF/ID register's job. This stage only redirects the PC.
- Counters wrap or saturate exactly as specified above. They have no other side effects.

## Timing
- Fetch latency is zero cycles: `instruction_out` and `pc_out` are valid combinationally in the same cycle the PC holds the address.
- Redirect: `branch_taken` sampled high at edge N means the outputs reflect `branch_addr` from edge N onward (one cycle after assertion).
- Freeze: `freeze` high for k cycles holds the outputs for k cycles. Sequential fetch resumes at the first edge where `freeze` is sampled low.
- Reset is synchronous. Outputs take their reset values after the first edge with `rst`=0:
  - `pc_out`=INIT_PC+4
  - `instruction_out`=mem[INIT_PC>>2] (or NOP if out of range)
  - faults 0, counters 0
- Reset asserted in the middle of a branch or freeze wins. Any simultaneous branch or freeze is discarded.
- The PC register, sticky flags and counters are the only state. No output is registered beyond them.

## Test plan
- Reset then 4 free-run cycles, with memory holding E3A01064, E3A020C8, E0813002, E5914000 → `pc_out` 4, 8, C, 10; `instruction_out` matches each word in turn; `fetch_count`=4.
- At PC=8, assert `freeze` for 3 cycles → PC holds at 8 for 3 cycles; `stall_count`=3; `fetch_count` unchanged; PC=C one cycle after release.
- At PC=14, pulse `branch_taken` with `branch_addr`=0x30 together with `freeze`=1 → next PC=0x30 (`pc_out`=0x34); `branch_count`=1; `stall_count` unchanged.
- Branch to 0x22 → PC=0x20 and `misalign_fault`=1; the flag stays 1 through 10 further cycles and clears only on reset.
- With MEM_DEPTH=64, branch to 0x100 → `instruction_out`=E1A00000 and `fetch_fault`=1 one cycle later; PC continues to 0x104.
- Pull `rst` low mid-freeze with `stall_count`=5 and PC=0x40 → after one edge, PC=INIT_PC, `stall_count`=0, `fetch_count`=0, faults 0.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: program counter, async-read instruction memory addressing,
// branch redirect / freeze handling, sticky fetch faults and performance counters.
module instr_fetch_stage #(
    parameter logic [31:0] INIT_PC   = 32'h0000_0000,
    parameter int          MEM_DEPTH = 64,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        fetch_fault,
    output logic        misalign_fault,
    output logic [31:0] fetch_count,
    output logic [15:0] stall_count,
    output logic [15:0] branch_count
);

    // One extra bit so a depth of 2^30 words still compares correctly against PC[31:2].
    localparam logic [30:0] DEPTH_WORDS = 31'(MEM_DEPTH);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        in_range;

    assign imem_addr = pc;
    assign pc_out    = pc_plus4;

    // NOTE: every signal driven here gets a value before any condition, so no latch is inferred.
    always_comb begin
        pc_plus4        = pc + 32'd4;
        in_range        = ({1'b0, pc[31:2]} < DEPTH_WORDS);
        instruction_out = NOP_INSTR;
        if (in_range) begin
            instruction_out = imem_rdata;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc             <= INIT_PC;
            fetch_fault    <= 1'b0;
            misalign_fault <= 1'b0;
            fetch_count    <= '0;
            stall_count    <= '0;
            branch_count   <= '0;
        end else begin
            // The fault reflects the address held this cycle, whatever the PC does next.
            if (!in_range) begin
                fetch_fault <= 1'b1;
            end

            if (branch_taken) begin
                pc           <= {branch_addr[31:2], 2'b00};
                fetch_count  <= fetch_count + 32'd1;
                branch_count <= branch_count + 16'd1;
                if (branch_addr[1:0] != 2'b00) begin
                    misalign_fault <= 1'b1;
                end
            end else if (freeze) begin
                if (stall_count != 16'hFFFF) begin
                    stall_count <= stall_count + 16'd1;
                end
            end else begin
                pc          <= pc_plus4;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: the driver pushes hand-computed expectations into a
// scoreboard queue after each edge; a negedge monitor pops and compares them.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    typedef struct {
        string       tag;
        logic [31:0] pc_out;
        logic [31:0] instr;
        logic        ffault;
        logic        mfault;
        logic [31:0] fcount;
        logic [15:0] scount;
        logic [15:0] bcount;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        fetch_fault;
    logic        misalign_fault;
    logic [31:0] fetch_count;
    logic [15:0] stall_count;
    logic [15:0] branch_count;

    logic [31:0] mem [0:63];
    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    // Only 6 address bits decoded: out-of-range fetches alias to real words, which the NOP must hide.
    assign imem_rdata = mem[imem_addr[7:2]];

    instr_fetch_stage #(
        .INIT_PC  (32'h0000_0000),
        .MEM_DEPTH(64),
        .NOP_INSTR(NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pc_out         (pc_out),
        .instruction_out(instruction_out),
        .fetch_fault    (fetch_fault),
        .misalign_fault (misalign_fault),
        .fetch_count    (fetch_count),
        .stall_count    (stall_count),
        .branch_count   (branch_count)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and step past the next rising edge.
    task automatic step(input logic r, input logic f, input logic b, input logic [31:0] a);
        rst          = r;
        freeze       = f;
        branch_taken = b;
        branch_addr  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] po, input logic [31:0] ins,
                              input logic ff, input logic mf, input logic [31:0] fc,
                              input logic [15:0] sc, input logic [15:0] bc);
        exp_t e;
        e.tag = tag; e.pc_out = po; e.instr = ins; e.ffault = ff; e.mfault = mf;
        e.fcount = fc; e.scount = sc; e.bcount = bc;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, ".pc_out"},          pc_out,                 e.pc_out);
            check({e.tag, ".instruction_out"}, instruction_out,        e.instr);
            check({e.tag, ".imem_addr"},       imem_addr,              e.pc_out - 32'd4);
            check({e.tag, ".fetch_fault"},     {31'b0, fetch_fault},   {31'b0, e.ffault});
            check({e.tag, ".misalign_fault"},  {31'b0, misalign_fault}, {31'b0, e.mfault});
            check({e.tag, ".fetch_count"},     fetch_count,            e.fcount);
            check({e.tag, ".stall_count"},     {16'b0, stall_count},   {16'b0, e.scount});
            check({e.tag, ".branch_count"},    {16'b0, branch_count},  {16'b0, e.bcount});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem[0] = 32'hE3A0_1064;
        mem[1] = 32'hE3A0_20C8;
        mem[2] = 32'hE081_3002;
        mem[3] = 32'hE591_4000;
        for (int i = 4; i < 64; i++) mem[i] = 32'hA000_0000 | i;

        // Reset, then four sequential fetches.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("reset",  32'h4,  32'hE3A0_1064, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("run1",   32'h8,  32'hE3A0_20C8, 0, 0, 1, 0, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("run2",   32'hC,  32'hE081_3002, 0, 0, 2, 0, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("run3",   32'h10, 32'hE591_4000, 0, 0, 3, 0, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("run4",   32'h14, 32'hA000_0004, 0, 0, 4, 0, 0);

        // Reset again, advance to PC=8, freeze 3 cycles, release.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("reset2", 32'h4,  32'hE3A0_1064, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("at8",    32'hC,  32'hE081_3002, 0, 0, 2, 0, 0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        expect_out("frz1",   32'hC,  32'hE081_3002, 0, 0, 2, 1, 0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        expect_out("frz2",   32'hC,  32'hE081_3002, 0, 0, 2, 2, 0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        expect_out("frz3",   32'hC,  32'hE081_3002, 0, 0, 2, 3, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("resume", 32'h10, 32'hE591_4000, 0, 0, 3, 3, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("at14",   32'h18, 32'hA000_0005, 0, 0, 5, 3, 0);

        // Branch with simultaneous freeze: branch wins, no stall counted.
        step(1'b1, 1'b1, 1'b1, 32'h30);
        expect_out("br30",   32'h34, 32'hA000_000C, 0, 0, 6, 3, 1);

        // Misaligned branch target: PC aligned down, sticky flag.
        step(1'b1, 1'b0, 1'b1, 32'h22);
        expect_out("br22",   32'h24, 32'hA000_0008, 0, 1, 7, 3, 2);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            expect_out("mis_hold", 32'h24 + 32'(4 * k), 32'hA000_0000 | 32'(8 + k),
                       0, 1, 32'(7 + k), 3, 2);
        end

        // Out-of-range target: NOP substituted at once, fault one edge later, PC keeps advancing.
        step(1'b1, 1'b0, 1'b1, 32'h100);
        expect_out("br100",  32'h104, NOP, 0, 1, 18, 3, 3);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("oor1",   32'h108, NOP, 1, 1, 19, 3, 3);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        expect_out("oor_frz", 32'h108, NOP, 1, 1, 19, 4, 3);

        // Reset with a simultaneous branch: reset wins.
        step(1'b0, 1'b0, 1'b1, 32'h80);
        expect_out("rst_br", 32'h4,  32'hE3A0_1064, 0, 0, 0, 0, 0);

        // Branch to 0x40, freeze 5 cycles, then reset mid-freeze.
        step(1'b1, 1'b0, 1'b1, 32'h40);
        expect_out("br40",   32'h44, 32'hA000_0010, 0, 0, 1, 0, 1);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            expect_out("frz40", 32'h44, 32'hA000_0010, 0, 0, 1, 16'(k), 1);
        end
        step(1'b0, 1'b1, 1'b0, 32'h0);
        expect_out("rst_frz", 32'h4, 32'hE3A0_1064, 0, 0, 0, 0, 0);

        // Stall counter saturation.
        for (int k = 0; k < 65533; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        expect_out("sat_m1", 32'h4, 32'hE3A0_1064, 0, 0, 0, 16'hFFFE, 0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        expect_out("sat",    32'h4, 32'hE3A0_1064, 0, 0, 0, 16'hFFFF, 0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        expect_out("sat_hold", 32'h4, 32'hE3A0_1064, 0, 0, 0, 16'hFFFF, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        expect_out("sat_run", 32'h8, 32'hE3A0_20C8, 0, 0, 1, 16'hFFFF, 0);

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
